// File: rtl/simple_bus_if.sv
// simple_bus_if: host-side and device-side signal bundle of the simple_bus interconnect.
// The slave modport is the bus view; master is the view of the hosts/devices around it.
interface simple_bus_if #(
    parameter int NrHosts      = 1,
    parameter int NrDevices    = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    localparam int BeWidth = DataWidth / 8;

    logic [NrHosts-1:0]      host_req_i;
    logic [NrHosts-1:0]      host_gnt_o;
    logic [AddressWidth-1:0] host_addr_i   [NrHosts];
    logic [NrHosts-1:0]      host_we_i;
    logic [BeWidth-1:0]      host_be_i     [NrHosts];
    logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
    logic [NrHosts-1:0]      host_rvalid_o;
    logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
    logic [NrHosts-1:0]      host_err_o;

    logic [NrDevices-1:0]    device_req_o;
    logic [AddressWidth-1:0] device_addr_o  [NrDevices];
    logic [NrDevices-1:0]    device_we_o;
    logic [BeWidth-1:0]      device_be_o    [NrDevices];
    logic [DataWidth-1:0]    device_wdata_o [NrDevices];
    logic [NrDevices-1:0]    device_rvalid_i;
    logic [DataWidth-1:0]    device_rdata_i [NrDevices];
    logic [NrDevices-1:0]    device_err_i;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  device_rvalid_i, device_rdata_i, device_err_i
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output device_rvalid_i, device_rdata_i, device_err_i
    );
endinterface

// File: rtl/simple_bus.sv
// simple_bus: fixed-priority NrHosts-to-NrDevices interconnect, combinational request, 1-cycle response.
// Define BUS_DECODE_ERR_EN to make unmapped accesses complete with host_err_o=1.
module simple_bus #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    simple_bus_if.slave             bus,
    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

`ifdef BUS_DECODE_ERR_EN
    localparam logic DecodeErr = 1'b1;
`else
    localparam logic DecodeErr = 1'b0;
`endif

    logic                    winValid;
    logic [HostIdxW-1:0]     winIdx;
    logic [AddressWidth-1:0] winAddr;
    logic                    devHit;
    logic [DevIdxW-1:0]      devIdx;

    logic                    pending_q, pending_d;
    logic                    miss_q, miss_d;
    logic [HostIdxW-1:0]     hostSel_q, hostSel_d;
    logic [DevIdxW-1:0]      devSel_q, devSel_d;

    // Downward loops let the lowest index overwrite, giving fixed priority.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (bus.host_req_i[h]) begin
                winValid = 1'b1;
                winIdx   = HostIdxW'(h);
            end
        end
    end

    assign winAddr = bus.host_addr_i[winIdx];

    always_comb begin
        devHit = 1'b0;
        devIdx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((winAddr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                devHit = 1'b1;
                devIdx = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        bus.host_gnt_o = '0;
        if (winValid) begin
            bus.host_gnt_o[winIdx] = 1'b1;
        end
    end

    always_comb begin
        bus.device_req_o = '0;
        if (winValid && devHit) begin
            bus.device_req_o[devIdx] = 1'b1;
        end
        for (int d = 0; d < NrDevices; d++) begin
            bus.device_addr_o[d]  = winAddr;
            bus.device_we_o[d]    = bus.host_we_i[winIdx];
            bus.device_be_o[d]    = bus.host_be_i[winIdx];
            bus.device_wdata_o[d] = bus.host_wdata_i[winIdx];
        end
    end

    always_comb begin
        pending_d = winValid;
        miss_d    = winValid & ~devHit;
        hostSel_d = winValid ? winIdx : hostSel_q;
        devSel_d  = winValid ? devIdx : devSel_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            miss_q    <= 1'b0;
            hostSel_q <= '0;
            devSel_q  <= '0;
        end else begin
            pending_q <= pending_d;
            miss_q    <= miss_d;
            hostSel_q <= hostSel_d;
            devSel_q  <= devSel_d;
        end
    end

    // A miss is answered by the bus itself; otherwise the selected device is steered through.
    always_comb begin
        bus.host_rvalid_o = '0;
        bus.host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            bus.host_rdata_o[h] = '0;
        end
        if (pending_q) begin
            if (miss_q) begin
                bus.host_rvalid_o[hostSel_q] = 1'b1;
                bus.host_err_o[hostSel_q]    = DecodeErr;
            end else begin
                bus.host_rvalid_o[hostSel_q] = bus.device_rvalid_i[devSel_q];
                bus.host_rdata_o[hostSel_q]  = bus.device_rdata_i[devSel_q];
                bus.host_err_o[hostSel_q]    = bus.device_err_i[devSel_q];
            end
        end
    end
endmodule

// File: tb/tb_simple_bus.sv
// tb_simple_bus: directed vectors for simple_bus with a response scoreboard drained by a monitor.
// Two hosts, three devices mapped as in the system memory map.
module tb_simple_bus;
    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;

`ifdef BUS_DECODE_ERR_EN
    localparam logic ExpDecodeErr = 1'b1;
`else
    localparam logic ExpDecodeErr = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]    host;
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cfgBase [ND];
    logic [AW-1:0] cfgMask [ND];

    resp_t         expQ[$];
    int            checks;
    int            failures;
    logic [ND-1:0] pendDev;
    logic [DW-1:0] pendData;
    logic          pendErr;

    simple_bus_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

    simple_bus #(
        .NrDevices(ND),
        .NrHosts(NH),
        .DataWidth(DW),
        .AddressWidth(AW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus.slave),
        .cfg_device_addr_base(cfgBase),
        .cfg_device_addr_mask(cfgMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // The device model answers the previous cycle's request; idle devices drive noise that must never reach a host.
    task automatic driveDevices();
        for (int d = 0; d < ND; d++) begin
            bus.device_rvalid_i[d] = pendDev[d];
            bus.device_rdata_i[d]  = pendDev[d] ? pendData : (32'hBAD0_0000 | 32'(d));
            bus.device_err_i[d]    = pendDev[d] ? pendErr : 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [NH-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic we, input logic [3:0] be, input logic [DW-1:0] wd,
                                 input logic [NH-1:0] expGnt, input logic [ND-1:0] expDev,
                                 input logic [DW-1:0] respData, input logic respErr, input logic discard);
        resp_t         e;
        logic [AW-1:0] winAddr;
        @(negedge clk);
        driveDevices();
        bus.host_req_i = req;
        bus.host_addr_i[0] = a0;
        bus.host_addr_i[1] = a1;
        for (int h = 0; h < NH; h++) begin
            bus.host_we_i[h]    = we;
            bus.host_be_i[h]    = be;
            bus.host_wdata_i[h] = wd;
        end
        #1;
        winAddr = expGnt[1] ? a1 : a0;
        checkOutput("gnt", 64'(bus.host_gnt_o), 64'(expGnt));
        checkOutput("device_req", 64'(bus.device_req_o), 64'(expDev));
        for (int d = 0; d < ND; d++) begin
            if (expDev[d]) begin
                checkOutput("device_addr", 64'(bus.device_addr_o[d]), 64'(winAddr));
                checkOutput("device_we", 64'(bus.device_we_o[d]), 64'(we));
                checkOutput("device_be", 64'(bus.device_be_o[d]), 64'(be));
                checkOutput("device_wdata", 64'(bus.device_wdata_o[d]), 64'(wd));
            end
        end
        if (expGnt != '0 && !discard) begin
            e.host  = expGnt[1] ? 8'd1 : 8'd0;
            e.rdata = (expDev != '0) ? respData : '0;
            e.err   = (expDev != '0) ? respErr : ExpDecodeErr;
            expQ.push_back(e);
        end
        pendDev  = expDev;
        pendData = respData;
        pendErr  = respErr;
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, '0, 1'b0, 4'h0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Reset lands while the device is answering a granted request; that response must vanish.
    task automatic resetPulse();
        @(negedge clk);
        driveDevices();
        bus.host_req_i = '0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        checkOutput("midreset_err", 64'(bus.host_err_o), 64'h0);
        checkOutput("midreset_rdata1", 64'(bus.host_rdata_o[1]), 64'h0);
        checkOutput("midreset_rdata0", 64'(bus.host_rdata_o[0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pendDev = '0;
        bus.device_rvalid_i = '1;
        bus.device_err_i = '1;
        #1;
        checkOutput("post_midreset_rvalid", 64'(bus.host_rvalid_o), 64'h0);
    endtask

    // Monitor: every host response is matched in order against the scoreboard.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            #3;
            for (int h = 0; h < NH; h++) begin
                if (bus.host_rvalid_o[h] === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_rvalid host=%0d actual=1 expected=0", h);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("resp_host", 64'(h), 64'(e.host));
                        checkOutput("resp_rdata", 64'(bus.host_rdata_o[h]), 64'(e.rdata));
                        checkOutput("resp_err", 64'(bus.host_err_o[h]), 64'(e.err));
                    end
                end else begin
                    checkOutput("quiet_host", {31'h0, bus.host_err_o[h], bus.host_rdata_o[h]}, 64'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        pendDev  = '0;
        pendData = '0;
        pendErr  = 1'b0;
        cfgBase[0] = 32'h0010_0000; cfgMask[0] = 32'hFFF0_0000;
        cfgBase[1] = 32'h0002_0000; cfgMask[1] = 32'hFFFF_FC00;
        cfgBase[2] = 32'h0003_0000; cfgMask[2] = 32'hFFFF_FC00;
        bus.host_req_i = '0;
        bus.host_we_i  = '0;
        for (int h = 0; h < NH; h++) begin
            bus.host_addr_i[h]  = '0;
            bus.host_be_i[h]    = '0;
            bus.host_wdata_i[h] = '0;
        end
        bus.device_rvalid_i = '0;
        bus.device_err_i    = '0;
        for (int d = 0; d < ND; d++) begin
            bus.device_rdata_i[d] = '0;
        end

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.device_rvalid_i = '1;
        bus.device_err_i    = '1;
        #1;
        checkOutput("reset_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        checkOutput("reset_err", 64'(bus.host_err_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        checkOutput("post_reset_err", 64'(bus.host_err_o), 64'h0);

        $display("[TB] single-host accesses");
        applyStimulus(2'b01, 32'h0010_0040, '0, 1'b0, 4'hF, '0, 2'b01, 3'b001, 32'hDEAD_BEEF, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'h0002_0000, '0, 1'b1, 4'b0001, 32'h41, 2'b01, 3'b010, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'h0003_0008, '0, 1'b0, 4'hF, '0, 2'b01, 3'b100, 32'h1234_5678, 1'b1, 1'b0);
        applyStimulus(2'b01, 32'h0005_0000, '0, 1'b0, 4'hF, '0, 2'b01, 3'b000, 32'h0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] two-host arbitration");
        applyStimulus(2'b11, 32'h0010_0000, 32'h0002_0004, 1'b0, 4'hF, '0, 2'b01, 3'b001, 32'h1111_0000, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h0010_0004, 32'h0002_0004, 1'b0, 4'hF, '0, 2'b01, 3'b001, 32'h1111_0004, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'h0, 32'h0002_0004, 1'b0, 4'hF, '0, 2'b10, 3'b010, 32'h2222_0004, 1'b0, 1'b0);
        applyStimulus(2'b10, 32'h0, 32'h0005_0000, 1'b0, 4'hF, '0, 2'b10, 3'b000, 32'h0, 1'b0, 1'b0);
        idleCycle();

        $display("[TB] back-to-back then reset");
        applyStimulus(2'b01, 32'h0010_0000, '0, 1'b0, 4'hF, '0, 2'b01, 3'b001, 32'hA5A5_0001, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'h0002_0004, '0, 1'b0, 4'hF, '0, 2'b01, 3'b010, 32'hB0B0_0002, 1'b0, 1'b1);
        resetPulse();
        idleCycle();
        idleCycle();

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
